int_src_ctl: RTL and testbench



---
 rtl/int_src_ctl.sv | 161 ++++++++++++++++
 tb/tb_int_src_ctl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_src_ctl.sv
// int_src_ctl: peripheral-side interrupt source controller.
// Latches rising edges of the event lines as pending, masks them and picks the
// lowest-index winner. Drives an active-low int_req and runs the
// request/acknowledge/RETI handshake against the core's int_ack.
// State changes only on ck edges where ck2 is low (active edges).
// The reset res is synchronous and active-low, and it acts regardless of ck2.
// Optional feature macro: INT_SRC_CTL_OVF_EN adds sticky per-source overflow
// flags (ovf) and their clear strobe (ovf_clr).
module int_src_ctl #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
) (
  input  logic            ck,
  input  logic            res,
  input  logic            ck2,
  input  logic [NSRC-1:0] src,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
`ifdef INT_SRC_CTL_OVF_EN
  input  logic            ovf_clr,
  output logic [NSRC-1:0] ovf,
`endif
  input  logic            int_ack,
  output logic            int_req,
  output logic [IDW-1:0]  int_id,
  output logic [NSRC-1:0] pend,
  output logic [NSRC-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx;
  logic [NSRC-1:0] hist_r;
  logic            active_s;
  logic [NSRC-1:0] rise_s;
  logic [NSRC-1:0] cand_s;
  logic            any_s;
  logic [IDW-1:0]  win_s;
  logic [NSRC-1:0] id_onehot_s;
  logic [NSRC-1:0] clr_s;
  logic [NSRC-1:0] pend_nx;
  logic            req_nx;
  logic [IDW-1:0]  id_nx;

  // Lowest set index of a request vector; 0 when the vector is empty.
  function automatic logic [IDW-1:0] pick_lowest(input logic [NSRC-1:0] v);
    logic [IDW-1:0] w;
    w = {IDW{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        w = IDW'(i);
      end
    end
    return w;
  endfunction

  assign active_s    = ~ck2;
  assign rise_s      = src & ~hist_r;
  assign cand_s      = pend & mask;
  assign any_s       = |cand_s;
  assign win_s       = pick_lowest(cand_s);
  assign id_onehot_s = {{(NSRC-1){1'b0}}, 1'b1} << int_id;
  // A new edge on the bit being cleared wins over the clear.
  assign pend_nx     = (pend & ~clr_s) | rise_s;

  // Next-state and next-output decode of the request/acknowledge handshake.
  always_comb begin
    state_nx = state_r;
    req_nx   = int_req;
    id_nx    = int_id;
    clr_s    = {NSRC{1'b0}};
    case (state_r)
      IDLE: begin
        // A stale int_ack is ignored here.
        req_nx = 1'b1;
        if (any_s) begin
          id_nx    = win_s;
          req_nx   = 1'b0;
          state_nx = REQ;
        end else begin
          state_nx = IDLE;
        end
      end
      REQ: begin
        // int_id stays frozen while requesting; an ack beats a same-edge mask write.
        req_nx = 1'b0;
        if (int_ack) begin
          clr_s    = id_onehot_s;
          req_nx   = 1'b1;
          state_nx = SERV;
        end else if (mask_we && !mask_wd[int_id]) begin
          req_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = REQ;
        end
      end
      SERV: begin
        // Falling int_ack marks RETI: service over.
        req_nx = 1'b1;
        if (!int_ack) begin
          state_nx = IDLE;
        end else begin
          state_nx = SERV;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b1;
        id_nx    = {IDW{1'b0}};
      end
    endcase
  end

  // Handshake, edge-detect, pending and mask registers; updated on active edges only.
  always_ff @(posedge ck) begin
    if (!res) begin
      state_r <= IDLE;
      int_req <= 1'b1;
      int_id  <= {IDW{1'b0}};
      pend    <= {NSRC{1'b0}};
      mask    <= {NSRC{1'b0}};
      hist_r  <= {NSRC{1'b0}};
    end else if (active_s) begin
      state_r <= state_nx;
      int_req <= req_nx;
      int_id  <= id_nx;
      pend    <= pend_nx;
      hist_r  <= src;
      if (mask_we) begin
        mask <= mask_wd;
      end
    end
  end

`ifdef INT_SRC_CTL_OVF_EN
  logic [NSRC-1:0] ovf_set_s;

  // A rising edge onto a still-pending bit that is not being cleared is an overflow.
  assign ovf_set_s = rise_s & pend & ~clr_s;

  // Sticky overflow flags; a same-edge set beats ovf_clr.
  always_ff @(posedge ck) begin
    if (!res) begin
      ovf <= {NSRC{1'b0}};
    end else if (active_s) begin
      if (ovf_clr) begin
        ovf <= ovf_set_s;
      end else begin
        ovf <= ovf | ovf_set_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_int_src_ctl.sv
// Directed testbench for int_src_ctl with hand-computed expectations.
module tb_int_src_ctl;

  logic       ck;
  logic       res;
  logic       ck2;
  logic [3:0] src;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic       int_ack;
  logic       int_req;
  logic [1:0] int_id;
  logic [3:0] pend;
  logic [3:0] mask;
`ifdef INT_SRC_CTL_OVF_EN
  logic       ovf_clr;
  logic [3:0] ovf;
`endif

  int n_chk;
  int n_pass;

  int_src_ctl #(.NSRC(4), .IDW(2)) dut (
    .ck      (ck),
    .res     (res),
    .ck2     (ck2),
    .src     (src),
    .mask_we (mask_we),
    .mask_wd (mask_wd),
`ifdef INT_SRC_CTL_OVF_EN
    .ovf_clr (ovf_clr),
    .ovf     (ovf),
`endif
    .int_ack (int_ack),
    .int_req (int_req),
    .int_id  (int_id),
    .pend    (pend),
    .mask    (mask)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b0;
    src = 4'b0000;
    int_ack = 1'b0;
    mask_we = 1'b0;
    tick();
    tick();
    res = 1'b1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_wd = m;
    tick();
    mask_we = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    res = 1'b0;
    ck2 = 1'b0;
    src = 4'b1111;
    mask_we = 1'b0;
    mask_wd = 4'b0000;
    int_ack = 1'b0;
`ifdef INT_SRC_CTL_OVF_EN
    ovf_clr = 1'b0;
`endif

    // Reset with all sources high
    tick();
    tick();
    check_eq("rst_req", 32'(int_req), 32'd1);
    check_eq("rst_pend", 32'(pend), 32'h0);
    check_eq("rst_mask", 32'(mask), 32'h0);
    check_eq("rst_id", 32'(int_id), 32'd0);
    res = 1'b1;
    tick();
    check_eq("rel_pend", 32'(pend), 32'hf);
    check_eq("rel_req", 32'(int_req), 32'd1);
    tick();
    check_eq("rel_req2", 32'(int_req), 32'd1);

    // Single event on source 2
    do_reset();
    write_mask(4'b0100);
    check_eq("se_mask", 32'(mask), 32'h4);
    src = 4'b0100;
    tick();
    check_eq("se_pend", 32'(pend), 32'h4);
    check_eq("se_req_e0", 32'(int_req), 32'd1);
    src = 4'b0000;
    tick();
    check_eq("se_req_e1", 32'(int_req), 32'd0);
    check_eq("se_id", 32'(int_id), 32'd2);
    int_ack = 1'b1;
    tick();
    check_eq("se_ack_req", 32'(int_req), 32'd1);
    check_eq("se_ack_pend", 32'(pend), 32'h0);
    tick();
    check_eq("se_serv_id", 32'(int_id), 32'd2);
    int_ack = 1'b0;
    tick();
    tick();
    check_eq("se_idle_req", 32'(int_req), 32'd1);

    // Priority and frozen id
    do_reset();
    write_mask(4'b1111);
    src = 4'b1000;
    tick();
    src = 4'b0000;
    tick();
    check_eq("pr_req", 32'(int_req), 32'd0);
    check_eq("pr_id3", 32'(int_id), 32'd3);
    src = 4'b0001;
    tick();
    check_eq("pr_pend", 32'(pend), 32'h9);
    src = 4'b0000;
    tick();
    check_eq("pr_frozen", 32'(int_id), 32'd3);
    int_ack = 1'b1;
    tick();
    check_eq("pr_ack_pend", 32'(pend), 32'h1);
    int_ack = 1'b0;
    tick();
    check_eq("pr_leave_req", 32'(int_req), 32'd1);
    tick();
    check_eq("pr_next_req", 32'(int_req), 32'd0);
    check_eq("pr_next_id", 32'(int_id), 32'd0);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tick();

    // ck2 gating
    do_reset();
    write_mask(4'b0010);
    ck2 = 1'b1;
    src = 4'b0010;
    tick();
    check_eq("g_hold_pend", 32'(pend), 32'h0);
    ck2 = 1'b0;
    src = 4'b0000;
    tick();
    check_eq("g_no_pend", 32'(pend), 32'h0);
    src = 4'b0010;
    tick();
    check_eq("g_pend", 32'(pend), 32'h2);
    ck2 = 1'b1;
    src = 4'b0000;
    tick();
    check_eq("g_req_hold", 32'(int_req), 32'd1);
    ck2 = 1'b0;
    tick();
    check_eq("g_req", 32'(int_req), 32'd0);
    ck2 = 1'b1;
    int_ack = 1'b1;
    tick();
    check_eq("g_ack_hold", 32'(int_req), 32'd0);
    ck2 = 1'b0;
    tick();
    check_eq("g_ack_req", 32'(int_req), 32'd1);
    check_eq("g_ack_pend", 32'(pend), 32'h0);
    int_ack = 1'b0;
    tick();

    // Reset mid-handshake while ck2 is high
    write_mask(4'b0010);
    src = 4'b0010;
    tick();
    src = 4'b0000;
    tick();
    check_eq("mr_req", 32'(int_req), 32'd0);
    ck2 = 1'b1;
    res = 1'b0;
    tick();
    check_eq("mr_rst_req", 32'(int_req), 32'd1);
    check_eq("mr_rst_pend", 32'(pend), 32'h0);
    ck2 = 1'b0;
    res = 1'b1;

    // Withdraw by masking the requested source
    do_reset();
    write_mask(4'b0010);
    src = 4'b0010;
    tick();
    src = 4'b0000;
    tick();
    check_eq("wd_id", 32'(int_id), 32'd1);
    write_mask(4'b0000);
    check_eq("wd_req", 32'(int_req), 32'd1);
    check_eq("wd_pend", 32'(pend), 32'h2);
    tick();
    check_eq("wd_idle_req", 32'(int_req), 32'd1);

    // Collision: new edge on serviced source at the ack edge
    do_reset();
    write_mask(4'b0010);
    src = 4'b0010;
    tick();
    src = 4'b0000;
    tick();
    src = 4'b0010;
    int_ack = 1'b1;
    tick();
    check_eq("co_req", 32'(int_req), 32'd1);
    check_eq("co_pend", 32'(pend), 32'h2);
    src = 4'b0000;
    tick();
    int_ack = 1'b0;
    tick();
    tick();
    check_eq("co_rereq", 32'(int_req), 32'd0);
    check_eq("co_reid", 32'(int_id), 32'd1);
    // Mask write and ack on the same edge: ack wins
    mask_we = 1'b1;
    mask_wd = 4'b0000;
    int_ack = 1'b1;
    tick();
    mask_we = 1'b0;
    check_eq("ma_pend", 32'(pend), 32'h0);
    check_eq("ma_req", 32'(int_req), 32'd1);
    int_ack = 1'b0;
    tick();

    // Repeated edges before service
    do_reset();
    src = 4'b0100;
    tick();
    src = 4'b0000;
    tick();
    src = 4'b0100;
    tick();
    src = 4'b0000;
    tick();
    check_eq("rp_pend", 32'(pend), 32'h4);
`ifdef INT_SRC_CTL_OVF_EN
    check_eq("ovf_set", 32'(ovf), 32'h4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovf_clr", 32'(ovf), 32'h0);
`endif
    write_mask(4'b0100);
    tick();
    check_eq("rp_req", 32'(int_req), 32'd0);
    check_eq("rp_id", 32'(int_id), 32'd2);
    int_ack = 1'b1;
    tick();
    check_eq("rp_ack_pend", 32'(pend), 32'h0);
    int_ack = 1'b0;
    tick();
    tick();
    check_eq("rp_single", 32'(int_req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
